// File: rtl/mem_stage_seq.sv
// LC-3b memory-stage sequencer: plain, byte and indirect (LDI/STI) accesses over a line-wide Wishbone master.
// Optional MEM_STAGE_STATS_EN adds saturating access/stall counters.
module mem_stage_seq #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  input  logic                                    req_write,
  input  logic                                    req_indirect,
  input  logic                                    req_byte,
  input  logic [ADDR_W-1:0]                       req_addr,
  input  logic [WORD_W-1:0]                       req_wdata,
  output logic                                    proceed,
  output logic [WORD_W-1:0]                       rdata,
  output logic [ADDR_W-$clog2(LINE_W/8)-1:0]      wb_adr,
  output logic [LINE_W-1:0]                       wb_dat_m,
  output logic [LINE_W/8-1:0]                     wb_sel,
  output logic                                    wb_we,
  output logic                                    wb_stb,
  output logic                                    wb_cyc,
  input  logic [LINE_W-1:0]                       wb_dat_s,
`ifdef MEM_STAGE_STATS_EN
  output logic [31:0]                             stat_acc,
  output logic [31:0]                             stat_stall,
`endif
  input  logic                                    wb_ack
);

  localparam int unsigned LANES  = LINE_W / 8;
  localparam int unsigned OFF_W  = $clog2(LANES);
  localparam int unsigned WLANES = WORD_W / 8;
  localparam int unsigned WOFF   = $clog2(WLANES);

  typedef enum logic [2:0] {IDLE, ACCESS, PTR, IND_ACCESS, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              wr_q;
  logic              byte_q;

  logic [OFF_W-WOFF-1:0] widx;
  logic [OFF_W-1:0]      bidx;
  logic                  byte_act;
  logic [WORD_W-1:0]     rd_word;
  logic [7:0]            rd_byte;
  logic [LANES-1:0]      sel_calc;

  assign widx     = addr_q[OFF_W-1:WOFF];
  assign bidx     = addr_q[OFF_W-1:0];
  // The pointer fetch is always a full word, whatever the final access size.
  assign byte_act = byte_q && (state != PTR);

  always_comb begin
    rd_word  = WORD_W'(wb_dat_s >> (WORD_W * widx));
    rd_byte  = 8'(wb_dat_s >> (8 * bidx));
    sel_calc = byte_act ? (LANES'(1) << bidx)
                        : (LANES'({WLANES{1'b1}}) << (WLANES * widx));
    wb_dat_m = byte_act ? {LANES{wdata_q[7:0]}}
                        : (LINE_W'(wdata_q) << (WORD_W * widx));
  end

  assign wb_adr  = addr_q[ADDR_W-1:OFF_W];
  assign wb_sel  = wb_stb ? sel_calc : '0;
  assign proceed = !rst && (((state == IDLE) && !req_valid) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      wb_stb  <= 1'b0;
      wb_cyc  <= 1'b0;
      wb_we   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_write;
            byte_q  <= req_byte;
            wb_stb  <= 1'b1;
            wb_cyc  <= 1'b1;
            if (req_indirect) begin
              state <= PTR;
              wb_we <= 1'b0;
            end else begin
              state <= ACCESS;
              wb_we <= req_write;
            end
          end
        end
        PTR: begin
          if (wb_ack) begin
            addr_q <= ADDR_W'(rd_word);
            wb_stb <= 1'b0;
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            state  <= IND_ACCESS;
          end
        end
        ACCESS, IND_ACCESS: begin
          // IND_ACCESS enters with the bus idle for one cycle, then strobes.
          if (!wb_stb) begin
            wb_stb <= 1'b1;
            wb_cyc <= 1'b1;
            wb_we  <= wr_q;
          end else if (wb_ack) begin
            wb_stb <= 1'b0;
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            if (!wr_q)
              rdata <= byte_act ? {{(WORD_W-8){1'b0}}, rd_byte} : rd_word;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_acc   <= '0;
      stat_stall <= '0;
    end else begin
      if ((state == DONE) && (stat_acc != '1))
        stat_acc <= stat_acc + 32'd1;
      if (req_valid && !proceed && (stat_stall != '1))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
